// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// A post-reset sweep (INIT) clears the table one entry per cycle, then the
// predictor runs: combinational lookup on fetch_pc, training from execute,
// and a registered flush/redirect pulse on each mispredict.
// Optional macro BP_PERF_CNT_EN adds perf_updates / perf_mispredicts counters.
module branch_predictor #(
  parameter int unsigned REG_SIZE = 32,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_SIZE-1:0] fetch_pc,
  output logic                pred_taken,
  output logic [REG_SIZE-1:0] pred_target,
  output logic                ready,
  input  logic                upd_valid,
  input  logic [REG_SIZE-1:0] upd_pc,
  input  logic                upd_is_jump,
  input  logic                upd_taken,
  input  logic [REG_SIZE-1:0] upd_target,
  input  logic                upd_pred_taken,
  input  logic [REG_SIZE-1:0] upd_pred_target,
  output logic                flush,
  output logic [REG_SIZE-1:0] redirect_pc
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]         perf_updates,
  output logic [31:0]         perf_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned TAG_W   = REG_SIZE - IDX_BITS - 2;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [REG_SIZE-1:0] target;
    logic                jump;
    logic [1:0]          ctr;
  } entry_t;

  entry_t tbl [ENTRIES];

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [IDX_BITS-1:0] f_idx, u_idx, wr_idx;
  logic [TAG_W-1:0]    f_tag, u_tag;
  entry_t              f_ent, u_ent, wr_ent;
  logic                run, upd_run, u_hit, mispredict, wr_en;

  assign run     = (state_q == S_RUN);
  assign ready   = run;
  assign f_idx   = fetch_pc[IDX_BITS+1:2];
  assign f_tag   = fetch_pc[REG_SIZE-1:IDX_BITS+2];
  assign u_idx   = upd_pc[IDX_BITS+1:2];
  assign u_tag   = upd_pc[REG_SIZE-1:IDX_BITS+2];
  assign f_ent   = tbl[f_idx];
  assign u_ent   = tbl[u_idx];
  assign u_hit   = u_ent.valid && (u_ent.tag == u_tag);
  assign upd_run = run && upd_valid;
  assign mispredict = upd_run && ((upd_taken != upd_pred_taken) ||
                                  (upd_taken && (upd_target != upd_pred_target)));

  // Lookup reads pre-update table contents, so a same-cycle update shows next cycle
  always_comb begin
    pred_taken  = run && f_ent.valid && (f_ent.tag == f_tag) &&
                  (f_ent.jump || f_ent.ctr[1]);
    pred_target = pred_taken ? f_ent.target : fetch_pc + REG_SIZE'(4);
  end

  // State and sweep index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state plus table write selection: sweep clear in INIT, training in RUN
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    wr_ent     = '0;
    unique case (state_q)
      S_INIT: begin
        wr_en      = 1'b1;
        wr_ent.ctr = 2'b01;
        idx_d      = idx_q + IDX_BITS'(1);
        if (idx_q == IDX_BITS'(ENTRIES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (upd_valid) begin
          wr_idx = u_idx;
          if (u_hit) begin
            wr_en       = 1'b1;
            wr_ent      = u_ent;
            wr_ent.jump = upd_is_jump;
            if (upd_taken) begin
              wr_ent.target = upd_target;
              wr_ent.ctr    = (u_ent.ctr == 2'b11) ? 2'b11 : u_ent.ctr + 2'd1;
            end else begin
              wr_ent.ctr    = (u_ent.ctr == 2'b00) ? 2'b00 : u_ent.ctr - 2'd1;
            end
          end else if (upd_taken) begin
            wr_en         = 1'b1;
            wr_ent.valid  = 1'b1;
            wr_ent.tag    = u_tag;
            wr_ent.target = upd_target;
            wr_ent.jump   = upd_is_jump;
            wr_ent.ctr    = 2'b10;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Table storage; no reset, the INIT sweep clears it
  always_ff @(posedge clk) begin
    if (wr_en && !rst) tbl[wr_idx] <= wr_ent;
  end

  // Registered one-cycle flush pulse with the corrected fetch address
  always_ff @(posedge clk) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) redirect_pc <= upd_taken ? upd_target : upd_pc + REG_SIZE'(4);
    end
  end

`ifdef BP_PERF_CNT_EN
  // Free-running update / mispredict counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_updates     <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (upd_run)    perf_updates     <= perf_updates + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default build).
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush;
  logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_updates;
  logic [31:0] perf_mispredicts;
`endif

  int errors = 0;
  int checks = 0;

  branch_predictor #(.REG_SIZE(32), .IDX_BITS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .ready           (ready),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_jump     (upd_is_jump),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush           (flush),
    .redirect_pc     (redirect_pc)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_updates    (perf_updates),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one update for a single cycle; returns #1 after the sampling edge
  task automatic drive_upd(input logic [31:0] pc, input logic jmp, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_is_jump = jmp; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0b exp 0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect: got %h exp 0", redirect_pc); end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      fetch_pc = 32'h40 + 32'(i) * 32'h4;
      #1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL init_ready c%0d: got %0b exp 0", i, ready); end
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL init_pred c%0d: got %0b exp 0", i, pred_taken); end
      checks++; if (pred_target !== fetch_pc + 32'h4) begin errors++; $display("FAIL init_tgt c%0d: got %h exp %h", i, pred_target, fetch_pc + 32'h4); end
      if (i == 4) begin
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL init_upd_flush: got %0b exp 0", flush); end
      end
      if (i == 3) drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
      else begin @(posedge clk); #1; end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL run_ready: got %0b exp 1", ready); end
    fetch_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL init_upd_ignored: got %0b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL init_upd_tgt: got %h exp 44", pred_target); end
  endtask

  task automatic test_alloc();
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL alloc_flush: got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL alloc_redirect: got %h exp 100", redirect_pc); end
    fetch_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %0b exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h100) begin errors++; $display("FAIL alloc_tgt: got %h exp 100", pred_target); end
    @(posedge clk); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL alloc_pulse: got %0b exp 0", flush); end
  endtask

  task automatic test_counter();
    // 10 -> 01, mispredicted as taken
    drive_upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL nt_flush: got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL nt_redirect: got %h exp 44", redirect_pc); end
    for (int i = 0; i < 3; i++) drive_upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_correct_flush: got %0b exp 0", flush); end
    fetch_pc = 32'h40; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr00_pred: got %0b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL ctr00_tgt: got %h exp 44", pred_target); end
    // fifth not-taken stays at 00; one taken brings it only to 01
    drive_upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL t01_redirect: got %h exp 100", redirect_pc); end
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low_pred: got %0b exp 0", pred_taken); end
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr10_pred: got %0b exp 1", pred_taken); end
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL correct_t_flush: got %0b exp 0", flush); end
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100);
    // saturated at 11, one not-taken leaves 10: still taken
    drive_upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL sat_high_pred: got %0b exp 1", pred_taken); end
    // wrong target with right direction
    drive_upd(32'h40, 1'b0, 1'b1, 32'h180, 1'b1, 32'h100);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL tgt_mis_flush: got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h180) begin errors++; $display("FAIL tgt_mis_redirect: got %h exp 180", redirect_pc); end
    checks++; if (pred_target !== 32'h180) begin errors++; $display("FAIL tgt_update: got %h exp 180", pred_target); end
  endtask

  task automatic test_alias();
    fetch_pc = 32'h440; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_pred: got %0b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h444) begin errors++; $display("FAIL alias_tgt: got %h exp 444", pred_target); end
    drive_upd(32'h440, 1'b0, 1'b0, 32'h0, 1'b0, 32'h444);
    fetch_pc = 32'h40; #1;
    checks++; if (pred_target !== 32'h180) begin errors++; $display("FAIL alias_nt_noalloc: got %h exp 180", pred_target); end
  endtask

  task automatic test_jump();
    drive_upd(32'h80, 1'b1, 1'b1, 32'h200, 1'b0, 32'h84);
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL jal_redirect: got %h exp 200", redirect_pc); end
    for (int i = 0; i < 3; i++) drive_upd(32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    checks++; if (redirect_pc !== 32'h84) begin errors++; $display("FAIL jal_nt_redirect: got %h exp 84", redirect_pc); end
    fetch_pc = 32'h80; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jump_pred: got %0b exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h200) begin errors++; $display("FAIL jump_tgt: got %h exp 200", pred_target); end
    fetch_pc = 32'h40; #1;
    checks++; if (pred_target !== 32'h44) begin errors++; $display("FAIL replaced_tgt: got %h exp 44", pred_target); end
  endtask

  task automatic test_same_cycle();
    fetch_pc = 32'h104;
    upd_valid = 1'b1; upd_pc = 32'h104; upd_is_jump = 1'b0; upd_taken = 1'b1;
    upd_target = 32'h300; upd_pred_taken = 1'b0; upd_pred_target = 32'h108;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_pre_pred: got %0b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h108) begin errors++; $display("FAIL same_pre_tgt: got %h exp 108", pred_target); end
    @(posedge clk); #1;
    upd_valid = 1'b0; #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_post_pred: got %0b exp 1", pred_taken); end
    checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL same_post_tgt: got %h exp 300", pred_target); end
  endtask

  task automatic test_back_to_back();
    upd_valid = 1'b1; upd_pc = 32'h208; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b1; upd_pred_target = 32'h300;
    @(posedge clk); #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush1: got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h20c) begin errors++; $display("FAIL b2b_redirect1: got %h exp 20c", redirect_pc); end
    upd_pc = 32'h30c; upd_taken = 1'b1; upd_target = 32'h400; upd_pred_taken = 1'b0;
    @(posedge clk); #1;
    upd_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush2: got %0b exp 1", flush); end
    checks++; if (redirect_pc !== 32'h400) begin errors++; $display("FAIL b2b_redirect2: got %h exp 400", redirect_pc); end
    @(posedge clk); #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b exp 0", flush); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    drive_upd(32'h104, 1'b0, 1'b1, 32'h500, 1'b1, 32'h300);
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstupd_flush: got %0b exp 0", flush); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstupd_ready: got %0b exp 0", ready); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rstupd_redirect: got %h exp 0", redirect_pc); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL resweep_ready c%0d: got %0b exp 0", i, ready); end
      @(posedge clk); #1;
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL resweep_done: got %0b exp 1", ready); end
    fetch_pc = 32'h104; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL resweep_clear: got %0b exp 0", pred_taken); end
    checks++; if (pred_target !== 32'h108) begin errors++; $display("FAIL resweep_tgt: got %h exp 108", pred_target); end
  endtask

  initial begin
    rst = 1'b1; fetch_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_jump();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
